mem_ram_pipelined: RTL and testbench

- Parametrised single-port synchronous RAM; next generation of the team's simple memory block.
- Adds per-byte write enables, configurable read latency with a fully pipelined read path, and a self-clearing init sequence after reset.
- Adds out-of-range error reporting for a DEPTH smaller than 2^ADDR_WIDTH.
- Sits behind the memory interface as the DUT driven by the UVM memory agent.

---
 rtl/mem_ram_pipelined.sv | 108 ++++++++++
 tb/tb_mem_ram_pipelined.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ram_pipelined.sv
// Single-port synchronous RAM with per-byte write enables, a fully pipelined read path
// of READ_LATENCY stages, a post-reset clearing sequence and out-of-range reporting.
module mem_ram_pipelined #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    ready,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    valid_out,
   output logic                    err_out
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   // Handshake: a request is accepted at a rising edge where en=1 and ready=1; a read
   // returns exactly READ_LATENCY edges later as a one-cycle valid_out pulse, in order.
   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        init_cnt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    in_range;
   logic [IDX_W-1:0]        idx;
   logic                    wr_go;
   logic                    rd_go;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic [READ_LATENCY-1:0] pv;
   logic [READ_LATENCY-1:0] pe;
   logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

   assign in_range = ({1'b0, address} < DEPTH_EXT);
   assign idx      = address[IDX_W-1:0];
   assign wr_go    = en & ready & we & in_range;
   assign rd_go    = en & ready & ~we;
   assign rd_word  = in_range ? mem[idx] : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (init_cnt == LAST_IDX) state_nxt = ST_IDLE;
         ST_IDLE: state_nxt = ST_IDLE;
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         ready    <= 1'b0;
      end else begin
         state <= state_nxt;
         ready <= (state_nxt == ST_IDLE);
         if (state == ST_INIT && init_cnt != LAST_IDX)
            init_cnt <= init_cnt + 1'b1;
      end
   end

   // Storage carries no reset; the INIT sweep is what clears it.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
         end else if (wr_go) begin
            for (int i = 0; i < BE_W; i++)
               if (be[i]) mem[idx][8*i +: 8] <= data_in[8*i +: 8];
         end
      end
   end

   // Data stages load only behind a valid, so the last stage holds the last returned word.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pv <= '0;
         pe <= '0;
         for (int k = 0; k < READ_LATENCY; k++) pd[k] <= '0;
      end else begin
         pv[0] <= rd_go;
         pe[0] <= rd_go & ~in_range;
         if (rd_go) pd[0] <= rd_word;
         for (int k = 1; k < READ_LATENCY; k++) begin
            pv[k] <= pv[k-1];
            pe[k] <= pe[k-1];
            if (pv[k-1]) pd[k] <= pd[k-1];
         end
      end
   end

   assign valid_out = pv[READ_LATENCY-1];
   assign err_out   = pe[READ_LATENCY-1];
   assign data_out  = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_ram_pipelined.sv
// Self-checking bench for mem_ram_pipelined: scenario tasks plus a read-return scoreboard.
module tb_mem_ram_pipelined;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 12;
   localparam int RL    = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          en = 1'b0;
   logic          we = 1'b0;
   logic [3:0]    be = '0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] data_in = '0;
   logic          ready;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          err_out;

   logic [DW-1:0] exp_q[$];
   logic          err_q[$];
   logic [DW-1:0] model [DEPTH];
   int            pass_cnt = 0;
   int            total_cnt = 0;

   mem_ram_pipelined #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .we(we), .be(be), .address(address),
      .data_in(data_in), .ready(ready), .data_out(data_out), .valid_out(valid_out),
      .err_out(err_out)
   );

   always #5 clk = ~clk;

   // Every returned read is checked against the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [DW-1:0] exp_d;
      logic          exp_e;
      if (valid_out === 1'b1) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_valid: got data=%h err=%b, required no return", data_out, err_out);
         end else begin
            exp_d = exp_q.pop_front();
            exp_e = err_q.pop_front();
            if (data_out !== exp_d || err_out !== exp_e)
               $display("FAIL read_return: got data=%h err=%b, required data=%h err=%b",
                        data_out, err_out, exp_d, exp_e);
            else
               pass_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
      en = 1'b1; we = 1'b1; address = a; data_in = d; be = b;
      tick();
      en = 1'b0; we = 1'b0;
      if (int'(a) < DEPTH)
         for (int i = 0; i < 4; i++)
            if (b[i]) model[int'(a)][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic read_word(input logic [AW-1:0] a, input bit expect_ret);
      en = 1'b1; we = 1'b0; address = a;
      if (expect_ret) begin
         if (int'(a) < DEPTH) begin
            exp_q.push_back(model[int'(a)]);
            err_q.push_back(1'b0);
         end else begin
            exp_q.push_back('0);
            err_q.push_back(1'b1);
         end
      end
      tick();
      en = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      total_cnt++;
      if (exp_q.size() != 0) begin
         $display("FAIL %s_drain: got %0d reads outstanding, required 0", tag, exp_q.size());
         exp_q.delete();
         err_q.delete();
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic check_init_window(input string tag);
      logic exp_r;
      for (int i = 1; i <= DEPTH; i++) begin
         tick();
         exp_r = (i == DEPTH);
         total_cnt++;
         if (ready !== exp_r || valid_out !== 1'b0 || err_out !== 1'b0)
            $display("FAIL %s_init_edge%0d: got ready=%b valid=%b err=%b, required ready=%b valid=0 err=0",
                     tag, i, ready, valid_out, err_out, exp_r);
         else
            pass_cnt++;
         if (i == DEPTH) begin
            en = 1'b0; we = 1'b0;
         end else begin
            address = AW'(i % DEPTH);
         end
      end
   endtask

   task automatic test_reset();
      en = 1'b1; we = 1'b0; address = 4'd3; reset_n = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if (ready !== 1'b0 || valid_out !== 1'b0 || err_out !== 1'b0 || data_out !== '0)
         $display("FAIL reset_state: got ready=%b valid=%b err=%b data=%h, required all 0",
                  ready, valid_out, err_out, data_out);
      else
         pass_cnt++;
      clear_model();
      reset_n = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         tick();
         total_cnt++;
         if (ready !== (i == DEPTH) || valid_out !== 1'b0)
            $display("FAIL init_ready_edge%0d: got ready=%b valid=%b, required ready=%b valid=0",
                     i, ready, valid_out, (i == DEPTH));
         else
            pass_cnt++;
      end
      exp_q.push_back('0);
      err_q.push_back(1'b0);
      tick();
      en = 1'b0;
      total_cnt++;
      if (valid_out !== 1'b0) $display("FAIL first_read_early: got valid=%b, required 0", valid_out);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (valid_out !== 1'b1) $display("FAIL first_read_latency: got valid=%b, required 1", valid_out);
      else pass_cnt++;
      drain("reset");
   endtask

   task automatic test_byte_enable();
      write_word(4'd5, 32'hAABBCCDD, 4'hF);
      write_word(4'd5, 32'h11223344, 4'b0101);
      write_word(4'd5, 32'h99999999, 4'b0000);
      exp_q.push_back(32'hAA22CC44);
      err_q.push_back(1'b0);
      read_word(4'd5, 1'b0);
      drain("byte_enable");
   endtask

   task automatic test_pipelined();
      int run;
      for (int k = 0; k < 4; k++) write_word(AW'(k), 32'h01010101 * k, 4'hF);
      run = 0;
      for (int k = 0; k < 4; k++) begin
         read_word(AW'(k), 1'b1);
         en = 1'b1;
         if (valid_out === 1'b1) run++;
      end
      en = 1'b0;
      tick();
      if (valid_out === 1'b1) run++;
      tick();
      total_cnt++;
      if (run !== 4 || valid_out !== 1'b0)
         $display("FAIL pipelined_valid_run: got %0d consecutive then valid=%b, required 4 then 0",
                  run, valid_out);
      else
         pass_cnt++;
      drain("pipelined");
   endtask

   task automatic test_out_of_range();
      write_word(4'd13, 32'hDEADBEEF, 4'hF);
      write_word(4'd15, 32'hFEEDFACE, 4'hF);
      read_word(4'd13, 1'b1);
      read_word(4'd11, 1'b1);
      read_word(4'd1, 1'b1);
      read_word(4'd3, 1'b1);
      drain("out_of_range");
   endtask

   task automatic test_read_after_write();
      write_word(4'd7, 32'hCAFEF00D, 4'hF);
      exp_q.push_back(32'hCAFEF00D);
      err_q.push_back(1'b0);
      read_word(4'd7, 1'b0);
      drain("read_after_write");
   endtask

   task automatic test_reset_mid_read();
      write_word(4'd2, 32'h12345678, 4'hF);
      read_word(4'd2, 1'b0);
      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total_cnt++;
         if (valid_out !== 1'b0 || ready !== 1'b0)
            $display("FAIL mid_read_flush%0d: got valid=%b ready=%b, required 0 0", i, valid_out, ready);
         else
            pass_cnt++;
      end
      clear_model();
      en = 1'b1; we = 1'b1; be = 4'hF; data_in = 32'hFFFFFFFF; address = '0;
      reset_n = 1'b1;
      check_init_window("mid_read");
      for (int a = 0; a < DEPTH; a++) read_word(AW'(a), 1'b1);
      drain("mid_read_sweep");
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int n = 0; n < 60; n++) begin
         a = AW'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1)
            write_word(a, $urandom, 4'($urandom_range(0, 15)));
         else
            read_word(a, 1'b1);
      end
      drain("random");
   endtask

   initial begin
      test_reset();
      test_byte_enable();
      test_pipelined();
      test_out_of_range();
      test_reset_mid_read();
      test_read_after_write();
      test_random();
      repeat (4) tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
